// File: rtl/comma_aligner.sv
// Receive word aligner: hunts for the K28.5 comma in a serial bit stream, locks the
// 10-bit symbol boundary to it and emits aligned symbols with lock/alignment status.
module comma_aligner #(
  parameter int P_LOCK_CNT   = 3,
  parameter int P_UNLOCK_CNT = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Bit,
  input  logic       i_Bit_Vld,
  input  logic       i_Realign,
  output logic [9:0] o_Word,
  output logic       o_Word_Vld,
  output logic       o_Is_Comma,
  output logic       o_Locked,
  output logic       o_Align_Err
);

  localparam logic [9:0] K28_5_NEG    = 10'b0011111010;
  localparam logic [9:0] K28_5_POS    = 10'b1100000101;
  localparam logic [3:0] LOCK_CNT_C   = 4'(P_LOCK_CNT);
  localparam logic [3:0] UNLOCK_CNT_C = 4'(P_UNLOCK_CNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic is_k28_5(input logic [9:0] w);
    return (w == K28_5_NEG) || (w == K28_5_POS);
  endfunction

  state_t     state_r, state_next_s;
  logic [9:0] win_r, win_next_s;
  logic [3:0] phase_r, phase_next_s;
  logic [3:0] good_cnt_r, good_next_s;
  logic [3:0] bad_cnt_r, bad_next_s;
  logic       comma_hit_s, boundary_s, emit_s, err_s;
  logic [9:0] word_r;
  logic       word_vld_r, is_comma_r, locked_r, align_err_r;

  assign win_next_s  = i_Bit_Vld ? {win_r[8:0], i_Bit} : win_r;
  assign comma_hit_s = i_Bit_Vld & is_k28_5(win_next_s);
  assign boundary_s  = i_Bit_Vld & (phase_r == 4'd9);

  // Next-state, counter and strobe decode for the hunt/check/locked machine
  always_comb begin
    state_next_s = state_r;
    phase_next_s = phase_r;
    good_next_s  = good_cnt_r;
    bad_next_s   = bad_cnt_r;
    emit_s       = 1'b0;
    err_s        = 1'b0;
    if (i_Realign) begin
      state_next_s = ST_HUNT;
      phase_next_s = 4'd0;
      good_next_s  = 4'd0;
      bad_next_s   = 4'd0;
    end else if (i_Bit_Vld) begin
      if (boundary_s) begin
        phase_next_s = 4'd0;
      end else begin
        phase_next_s = phase_r + 4'd1;
      end
      case (state_r)
        ST_HUNT: begin
          if (comma_hit_s) begin
            emit_s       = 1'b1;
            phase_next_s = 4'd0;
            good_next_s  = 4'd1;
            bad_next_s   = 4'd0;
            if (LOCK_CNT_C <= 4'd1) begin
              state_next_s = ST_LOCKED;
            end else begin
              state_next_s = ST_CHECK;
            end
          end else begin
            state_next_s = ST_HUNT;
          end
        end
        ST_CHECK: begin
          if (boundary_s) begin
            emit_s = 1'b1;
            if (comma_hit_s) begin
              if ((good_cnt_r + 4'd1) >= LOCK_CNT_C) begin
                good_next_s  = LOCK_CNT_C;
                bad_next_s   = 4'd0;
                state_next_s = ST_LOCKED;
              end else begin
                good_next_s = good_cnt_r + 4'd1;
              end
            end else begin
              good_next_s = good_cnt_r;
            end
          end else if (comma_hit_s) begin
            // Off-boundary comma in CHECK re-anchors the boundary onto itself
            err_s        = 1'b1;
            emit_s       = 1'b1;
            phase_next_s = 4'd0;
            good_next_s  = 4'd1;
          end else begin
            state_next_s = ST_CHECK;
          end
        end
        ST_LOCKED: begin
          if (boundary_s) begin
            emit_s = 1'b1;
            if (comma_hit_s) begin
              bad_next_s = 4'd0;
            end else begin
              bad_next_s = bad_cnt_r;
            end
          end else if (comma_hit_s) begin
            err_s = 1'b1;
            if ((bad_cnt_r + 4'd1) >= UNLOCK_CNT_C) begin
              state_next_s = ST_HUNT;
              bad_next_s   = 4'd0;
              good_next_s  = 4'd0;
            end else begin
              bad_next_s = bad_cnt_r + 4'd1;
            end
          end else begin
            state_next_s = ST_LOCKED;
          end
        end
        default: begin
          state_next_s = ST_HUNT;
          good_next_s  = 4'd0;
          bad_next_s   = 4'd0;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // State, window and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r     <= ST_HUNT;
      win_r       <= 10'd0;
      phase_r     <= 4'd0;
      good_cnt_r  <= 4'd0;
      bad_cnt_r   <= 4'd0;
      word_r      <= 10'd0;
      word_vld_r  <= 1'b0;
      is_comma_r  <= 1'b0;
      locked_r    <= 1'b0;
      align_err_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      win_r       <= win_next_s;
      phase_r     <= phase_next_s;
      good_cnt_r  <= good_next_s;
      bad_cnt_r   <= bad_next_s;
      word_vld_r  <= emit_s;
      align_err_r <= err_s;
      locked_r    <= (state_next_s == ST_LOCKED);
      if (emit_s) begin
        word_r     <= win_next_s;
        is_comma_r <= comma_hit_s;
      end
    end
  end

  assign o_Word      = word_r;
  assign o_Word_Vld  = word_vld_r;
  assign o_Is_Comma  = is_comma_r;
  assign o_Locked    = locked_r;
  assign o_Align_Err = align_err_r;

endmodule
